// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch unit feeding the instruction FIFO.
//   clk, rst                  clock and asynchronous active-high reset
//   inst_req_valid/ready/addr request channel to the I-cache (8-byte aligned)
//   inst_resp_valid/data      single-cycle response pulse carrying two instructions
//   redirect_valid/pc         backend redirect; new PC with bits [1:0] cleared
//   fifo_full, fifo_rst       FIFO backpressure and flush (flush mirrors redirect_valid)
//   write_en1/2, write_entry1/2  FIFO slot writes, entry = {pc[63:0], inst[31:0]}
//   perf_fetch_cnt            running count of instructions written to the FIFO
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             inst_req_valid,
    input  logic             inst_req_ready,
    output logic [63:0]      inst_req_addr,
    input  logic             inst_resp_valid,
    input  logic [63:0]      inst_resp_data,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    input  logic             fifo_full,
    output logic             fifo_rst,
    output logic             write_en1,
    output logic             write_en2,
    output logic [95:0]      write_entry1,
    output logic [95:0]      write_entry2,
    output logic [CNT_W-1:0] perf_fetch_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DROP} state_t;
    state_t      state, state_n;
    logic [63:0] pc, pc_n, buf_data;
    logic        hs, redir, push;
    assign hs             = inst_req_valid && inst_req_ready;
    // A redirect before the first request has nothing to cancel.
    assign redir          = redirect_valid && (state != S_IDLE);
    assign push           = (state == S_PUSH) && !fifo_full && !redirect_valid;
    assign inst_req_valid = state == S_REQ;
    assign inst_req_addr  = inst_req_valid ? {pc[63:3], 3'b000} : '0;
    assign fifo_rst       = redirect_valid;
    // An odd-word PC only uses the upper half of the bundle.
    assign write_en1      = push;
    assign write_en2      = push && !pc[2];
    assign write_entry1   = write_en1 ? {pc, pc[2] ? buf_data[63:32] : buf_data[31:0]} : '0;
    assign write_entry2   = write_en2 ? {pc + 64'd4, buf_data[63:32]} : '0;
    always_comb begin
        state_n = state;
        pc_n    = redir ? (redirect_pc & ~64'h3) : push ? pc + (pc[2] ? 64'd4 : 64'd8) : pc;
        case (state)
            S_IDLE:  state_n = S_REQ;
            S_REQ:   state_n = hs ? (redir ? S_DROP : S_WAIT) : S_REQ;
            S_WAIT:  state_n = inst_resp_valid ? (redir ? S_REQ : S_PUSH) : (redir ? S_DROP : S_WAIT);
            S_PUSH:  state_n = (redir || !fifo_full) ? S_REQ : S_PUSH;
            S_DROP:  state_n = inst_resp_valid ? S_REQ : S_DROP;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            buf_data       <= '0;
            perf_fetch_cnt <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            if (state == S_WAIT && inst_resp_valid && !redir)
                buf_data <= inst_resp_data;
            perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(write_en1) + CNT_W'(write_en2);
        end
    end
    // A response is only legal while one is outstanding or being dropped.
    assert property (@(posedge clk) disable iff (rst)
        !(inst_resp_valid && (state == S_REQ || (state == S_PUSH && !redirect_valid))));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage request, split, redirect, stall and reset behaviour.
module tb_fetch_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic        inst_req_valid, inst_req_ready = 1;
    logic [63:0] inst_req_addr;
    logic        inst_resp_valid = 0;
    logic [63:0] inst_resp_data = '0;
    logic        redirect_valid = 0;
    logic [63:0] redirect_pc = '0;
    logic        fifo_full = 0, fifo_rst;
    logic        write_en1, write_en2;
    logic [95:0] write_entry1, write_entry2;
    logic [63:0] perf_fetch_cnt;
    int          errors = 0, checks = 0;
    fetch_stage dut (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_req_addr(inst_req_addr),
        .inst_resp_valid(inst_resp_valid), .inst_resp_data(inst_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fifo_full(fifo_full), .fifo_rst(fifo_rst),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_entry1(write_entry1), .write_entry2(write_entry2),
        .perf_fetch_cnt(perf_fetch_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    localparam logic [63:0] D1 = 64'h00200093_00100093;
    localparam logic [63:0] D2 = 64'hAAAA1111_BBBB2222;
    localparam logic [63:0] D3 = 64'h12345678_9ABCDEF0;
    localparam logic [63:0] D4 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D5 = 64'h0BADF00D_FEEDFACE;
    localparam logic [63:0] D6 = 64'h11112222_33334444;
    localparam logic [63:0] D7 = 64'h55556666_77778888;
    initial begin
        tick(); #1;
        chk("rst_valid", inst_req_valid, 0);
        chk("rst_addr", inst_req_addr, 0);
        chk("rst_en", {write_en1, write_en2}, 0);
        chk("rst_entries", {write_entry1, write_entry2}, 0);
        chk("rst_perf", perf_fetch_cnt, 0);
        rst = 0;
        // basic two-instruction bundle
        tick(); #1;
        chk("t1_valid", inst_req_valid, 1);
        chk("t1_addr", inst_req_addr, 64'h8000_0000);
        tick(); inst_resp_valid = 1; inst_resp_data = D1; #1;
        chk("t1_wait_en", write_en1, 0);
        tick(); inst_resp_valid = 0; #1;
        chk("t1_en", {write_en1, write_en2}, 2'b11);
        chk("t1_e1", write_entry1, {64'h8000_0000, 32'h0010_0093});
        chk("t1_e2", write_entry2, {64'h8000_0004, 32'h0020_0093});
        chk("t1_push_valid", inst_req_valid, 0);
        tick(); #1;
        chk("t1_next_addr", inst_req_addr, 64'h8000_0008);
        chk("t1_perf", perf_fetch_cnt, 2);
        // redirect in S_REQ to an odd word
        redirect_valid = 1; redirect_pc = 64'h8000_0104; inst_req_ready = 0; #1;
        chk("t2_fifo_rst", fifo_rst, 1);
        chk("t2_addr_hold", inst_req_addr, 64'h8000_0008);
        tick(); redirect_valid = 0; inst_req_ready = 1; #1;
        chk("t2_fifo_rst_off", fifo_rst, 0);
        chk("t2_addr", inst_req_addr, 64'h8000_0100);
        tick(); inst_resp_valid = 1; inst_resp_data = D2; #1;
        tick(); inst_resp_valid = 0; #1;
        chk("t2_en", {write_en1, write_en2}, 2'b10);
        chk("t2_e1", write_entry1, {64'h8000_0104, D2[63:32]});
        chk("t2_e2", write_entry2, 0);
        tick(); #1;
        chk("t2_next_addr", inst_req_addr, 64'h8000_0108);
        chk("t2_perf", perf_fetch_cnt, 3);
        // FIFO full for five cycles at the response
        tick(); inst_resp_valid = 1; inst_resp_data = D3; fifo_full = 1; #1;
        tick(); inst_resp_valid = 0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_en", {write_en1, write_en2}, 0);
            chk("t3_stall_valid", inst_req_valid, 0);
            if (i < 4) begin tick(); #1; end
        end
        tick(); fifo_full = 0; #1;
        chk("t3_en", {write_en1, write_en2}, 2'b11);
        chk("t3_e1", write_entry1, {64'h8000_0108, D3[31:0]});
        chk("t3_e2", write_entry2, {64'h8000_010C, D3[63:32]});
        tick(); #1;
        chk("t3_next_addr", inst_req_addr, 64'h8000_0110);
        chk("t3_perf", perf_fetch_cnt, 5);
        // redirect in S_WAIT, response three cycles later is dropped
        tick(); redirect_valid = 1; redirect_pc = 64'h8000_0200; #1;
        chk("t4_fifo_rst", fifo_rst, 1);
        tick(); redirect_valid = 0; #1;
        chk("t4_drop_valid", inst_req_valid, 0);
        tick(); #1;
        tick(); inst_resp_valid = 1; inst_resp_data = D4; #1;
        chk("t4_drop_en", write_en1, 0);
        tick(); inst_resp_valid = 0; #1;
        chk("t4_no_write", {write_en1, write_en2}, 0);
        chk("t4_valid", inst_req_valid, 1);
        chk("t4_addr", inst_req_addr, 64'h8000_0200);
        chk("t4_perf", perf_fetch_cnt, 5);
        // redirect coincident with response; low PC bits are discarded
        tick(); inst_resp_valid = 1; inst_resp_data = D4; redirect_valid = 1; redirect_pc = 64'h8000_0307; #1;
        chk("t5_en", {write_en1, write_en2}, 0);
        chk("t5_fifo_rst", fifo_rst, 1);
        tick(); inst_resp_valid = 0; redirect_valid = 0; #1;
        chk("t5_valid", inst_req_valid, 1);
        chk("t5_addr", inst_req_addr, 64'h8000_0300);
        chk("t5_perf", perf_fetch_cnt, 5);
        tick(); inst_resp_valid = 1; inst_resp_data = D5; #1;
        tick(); inst_resp_valid = 0; #1;
        chk("t5_en2", {write_en1, write_en2}, 2'b10);
        chk("t5_e1", write_entry1, {64'h8000_0304, D5[63:32]});
        tick(); #1;
        chk("t5_perf2", perf_fetch_cnt, 6);
        // asynchronous reset while a write is pending
        tick(); inst_resp_valid = 1; inst_resp_data = D6; #1;
        tick(); inst_resp_valid = 0; #1;
        chk("t6_pending", write_en1, 1);
        #1 rst = 1; #1;
        chk("t6_en", {write_en1, write_en2}, 0);
        chk("t6_valid", inst_req_valid, 0);
        chk("t6_entries", {write_entry1, write_entry2}, 0);
        chk("t6_perf", perf_fetch_cnt, 0);
        tick(); rst = 0; #1;
        tick(); #1;
        chk("t6_addr", inst_req_addr, 64'h8000_0000);
        chk("t6_valid2", inst_req_valid, 1);
        chk("t6_perf2", perf_fetch_cnt, 0);
        // PC wrap at the top of the address space
        redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8; inst_req_ready = 0; #1;
        tick(); redirect_valid = 0; inst_req_ready = 1; #1;
        chk("t7_addr", inst_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        tick(); inst_resp_valid = 1; inst_resp_data = D7; #1;
        tick(); inst_resp_valid = 0; #1;
        chk("t7_e1", write_entry1, {64'hFFFF_FFFF_FFFF_FFF8, D7[31:0]});
        chk("t7_e2", write_entry2, {64'hFFFF_FFFF_FFFF_FFFC, D7[63:32]});
        tick(); #1;
        chk("t7_wrap_addr", inst_req_addr, 64'h0);
        chk("t7_perf", perf_fetch_cnt, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
